// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit memory controller:
// funct3 size codes, major opcodes, FSM states and the alignment rule.
package lsu_mem_ctrl_pkg;

  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SD  = 3'b011;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SH  = 3'b001;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_D = 2'd0,
    SZ_W = 2'd1,
    SZ_H = 2'd2
  } size_e;

  // Any code outside the word/half set is handled as a doubleword.
  function automatic size_e size_of(input logic [2:0] f3);
    case (f3)
      F3_LW, F3_LWU: size_of = SZ_W;
      F3_LH, F3_LHU: size_of = SZ_H;
      default:       size_of = SZ_D;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] f3, input logic [2:0] off);
    case (size_of(f3))
      SZ_W:    is_aligned = (off[1:0] == 2'b00);
      SZ_H:    is_aligned = (off[0] == 1'b0);
      default: is_aligned = (off == 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store mask and data shifted up to their lane,
// load data shifted down so the addressed byte lands at bit 0.
module lsu_lane_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [2:0]  i_off,
  input  logic        i_is_store,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [7:0]  o_wmask,
  output logic [63:0] o_wdata_sh,
  output logic [63:0] o_rdata_sh
);

  logic [5:0] w_bit_off;

  assign w_bit_off  = {i_off, 3'b000};
  assign o_wdata_sh = i_wdata << w_bit_off;
  assign o_rdata_sh = i_rdata >> w_bit_off;

  // NOTE: every output of a combinational block is given a value before any
  // branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    o_wmask = 8'h00;
    if (i_is_store) begin
      case (size_of(i_funct3))
        SZ_W:    o_wmask = 8'h0F << i_off;
        SZ_H:    o_wmask = 8'h03 << i_off;
        default: o_wmask = 8'hFF;
      endcase
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller: one outstanding access, IDLE->WAIT->DONE,
// with a bounded wait for mem_ack that ends in a bus error.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int AW      = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic          is_load,
  input  logic          is_store,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  input  logic [4:0]    rd,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  output logic [7:0]    mem_wmask,
  input  logic          mem_ack,
  input  logic [63:0]   mem_rdata,
  output logic          stall,
  output logic          ld_done,
  output logic [63:0]   ld_rdata,
  output logic [2:0]    ld_funct3,
  output logic [4:0]    ld_rd,
  output logic          misalign,
  output logic          bus_err
);

  // The last WAIT cycle is the one in which the counter would step to TIMEOUT.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e        r_state, w_next;
  logic [7:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic [63:0]   r_wdata;
  logic [2:0]    r_funct3;
  logic [4:0]    r_rd;
  logic          r_we;
  logic          r_ld_done, r_bus_err;
  logic [63:0]   r_ld_rdata;
  logic [2:0]    r_ld_funct3;
  logic [4:0]    r_ld_rd;

  logic          w_start, w_aligned, w_go, w_ack, w_timeout;
  logic [63:0]   w_rdata_sh;

  assign w_start   = valid & (is_load | is_store) & (r_state == ST_IDLE);
  assign w_aligned = is_aligned(funct3, addr[2:0]);
  assign w_go      = w_start & w_aligned;
  assign w_ack     = (r_state == ST_WAIT) & mem_ack;
  assign w_timeout = (r_state == ST_WAIT) & ~mem_ack & (r_cnt == TO_LAST);

  lsu_lane_align u_lane (
    .i_funct3   (r_funct3),
    .i_off      (r_addr[2:0]),
    .i_is_store (r_we),
    .i_wdata    (r_wdata),
    .i_rdata    (mem_rdata),
    .o_wmask    (mem_wmask),
    .o_wdata_sh (mem_wdata),
    .o_rdata_sh (w_rdata_sh)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_go) w_next = ST_WAIT;
      ST_WAIT: if (mem_ack || r_cnt == TO_LAST) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and a synchronous reset, so
  // every register updates from pre-edge values and reset obeys the clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_funct3    <= '0;
      r_rd        <= '0;
      r_we        <= 1'b0;
      r_ld_done   <= 1'b0;
      r_bus_err   <= 1'b0;
      r_ld_rdata  <= '0;
      r_ld_funct3 <= '0;
      r_ld_rd     <= '0;
    end else begin
      r_state   <= w_next;
      r_ld_done <= w_ack & ~r_we;
      r_bus_err <= w_timeout;
      if (w_go) begin
        r_addr   <= addr;
        r_wdata  <= wdata;
        r_funct3 <= funct3;
        r_rd     <= rd;
        r_we     <= ~is_load;
        r_cnt    <= '0;
      end else if (r_state == ST_WAIT && !mem_ack) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_ack & ~r_we) begin
        r_ld_rdata  <= w_rdata_sh;
        r_ld_funct3 <= r_funct3;
        r_ld_rd     <= r_rd;
      end
    end
  end

  // Combinational strobes are masked during reset so reset forces them low.
  assign stall     = ~rst & (w_go | (r_state == ST_WAIT));
  assign misalign  = ~rst & w_start & ~w_aligned;
  assign mem_req   = (r_state == ST_WAIT);
  assign mem_we    = r_we;
  assign mem_addr  = {r_addr[AW-1:3], 3'b000};
  assign ld_done   = r_ld_done;
  assign bus_err   = r_bus_err;
  assign ld_rdata  = r_ld_rdata;
  assign ld_funct3 = r_ld_funct3;
  assign ld_rd     = r_ld_rd;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: loads, stores, misalignment, timeout
// boundary and reset abandonment, checked against hand-computed values.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [63:0] addr, wdata;
  logic [4:0]  rd;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        stall, ld_done;
  logic [63:0] ld_rdata;
  logic [2:0]  ld_funct3;
  logic [4:0]  ld_rd;
  logic        misalign, bus_err;

  int n_tests = 0;
  int n_fail  = 0;
  int wc;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT(255), .AW(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .is_load   (is_load),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rd        (rd),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .ld_done   (ld_done),
    .ld_rdata  (ld_rdata),
    .ld_funct3 (ld_funct3),
    .ld_rd     (ld_rd),
    .misalign  (misalign),
    .bus_err   (bus_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd, input logic [4:0] r);
    valid = v; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd; rd = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0);
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_mem_req",  64'(mem_req), 64'h0);
    check("rst_stall",    64'(stall), 64'h0);
    check("rst_ld_done",  64'(ld_done), 64'h0);
    check("rst_ld_rdata", ld_rdata, 64'h0);
    check("rst_wmask",    64'(mem_wmask), 64'h0);
    check("rst_bus_err",  64'(bus_err), 64'h0);
    rst = 1'b0;

    // LD at 0x100, ack in the first WAIT cycle
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b011, 64'h100, 64'h0, 5'd5);
    #1;
    check("ld_start_stall",  64'(stall), 64'h1);
    check("ld_start_req",    64'(mem_req), 64'h0);
    check("ld_start_misal",  64'(misalign), 64'h0);
    @(negedge clk);
    check("ld_wait_req",   64'(mem_req), 64'h1);
    check("ld_wait_addr",  mem_addr, 64'h100);
    check("ld_wait_we",    64'(mem_we), 64'h0);
    check("ld_wait_wmask", 64'(mem_wmask), 64'h0);
    check("ld_wait_stall", 64'(stall), 64'h1);
    valid = 1'b0; mem_ack = 1'b1; mem_rdata = 64'h1122334455667788;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 64'hDEADDEADDEADDEAD;
    check("ld_done_pulse", 64'(ld_done), 64'h1);
    check("ld_done_stall", 64'(stall), 64'h0);
    check("ld_done_req",   64'(mem_req), 64'h0);
    check("ld_rdata",      ld_rdata, 64'h1122334455667788);
    check("ld_rd",         64'(ld_rd), 64'd5);
    check("ld_funct3",     64'(ld_funct3), 64'h3);
    @(negedge clk);
    check("ld_done_end", 64'(ld_done), 64'h0);

    // SH at 0x106, ack delayed one cycle, valid held through DONE
    drive(1'b1, 1'b0, 1'b1, 3'b001, 64'h106, 64'hBEEF, 5'd9);
    #1;
    check("sh_start_stall", 64'(stall), 64'h1);
    @(negedge clk);
    check("sh_req",   64'(mem_req), 64'h1);
    check("sh_we",    64'(mem_we), 64'h1);
    check("sh_addr",  mem_addr, 64'h100);
    check("sh_wmask", 64'(mem_wmask), 64'hC0);
    check("sh_wdata", mem_wdata, 64'hBEEF000000000000);
    addr = 64'h0; wdata = 64'h0;
    @(negedge clk);
    check("sh_hold_req",   64'(mem_req), 64'h1);
    check("sh_hold_wdata", mem_wdata, 64'hBEEF000000000000);
    check("sh_hold_wmask", 64'(mem_wmask), 64'hC0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("sh_no_ld_done",   64'(ld_done), 64'h0);
    check("sh_no_bus_err",   64'(bus_err), 64'h0);
    check("sh_done_stall",   64'(stall), 64'h0);
    check("sh_keep_ld_data", ld_rdata, 64'h1122334455667788);
    @(negedge clk);
    valid = 1'b0;
    check("sh_no_restart_from_done", 64'(mem_req), 64'h0);

    // LW at 0x104: upper word shifted down
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 64'h104, 64'h0, 5'd7);
    @(negedge clk);
    check("lw_addr", mem_addr, 64'h100);
    valid = 1'b0; mem_ack = 1'b1; mem_rdata = 64'h8000000000000000;
    @(negedge clk);
    mem_ack = 1'b0;
    check("lw_done",   64'(ld_done), 64'h1);
    check("lw_rdata",  ld_rdata, 64'h0000000080000000);
    check("lw_funct3", 64'(ld_funct3), 64'h2);
    check("lw_rd",     64'(ld_rd), 64'd7);

    // Misaligned starts: pulse same cycle, no request, no stall
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 64'h102, 64'h0, 5'd1);
    #1;
    check("mis_lw_pulse", 64'(misalign), 64'h1);
    check("mis_lw_stall", 64'(stall), 64'h0);
    @(negedge clk);
    check("mis_lw_no_req", 64'(mem_req), 64'h0);
    drive(1'b1, 1'b0, 1'b1, 3'b001, 64'h107, 64'h0, 5'd0);
    #1;
    check("mis_sh_pulse", 64'(misalign), 64'h1);
    drive(1'b1, 1'b1, 1'b0, 3'b111, 64'h104, 64'h0, 5'd0);
    #1;
    check("mis_unlisted_as_d", 64'(misalign), 64'h1);
    drive(1'b1, 1'b1, 1'b0, 3'b110, 64'h104, 64'h0, 5'd0);
    #1;
    check("lwu_aligned_no_pulse", 64'(misalign), 64'h0);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    check("mis_idle_req", 64'(mem_req), 64'h0);

    // Timeout: no ack at all
    drive(1'b1, 1'b1, 1'b0, 3'b011, 64'h200, 64'h0, 5'd3);
    wc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      valid = 1'b0;
      if (!mem_req) break;
      wc++;
    end
    check("to_wait_cycles", 64'(wc), 64'd255);
    check("to_bus_err",     64'(bus_err), 64'h1);
    check("to_no_ld_done",  64'(ld_done), 64'h0);
    check("to_stall_free",  64'(stall), 64'h0);
    check("to_keep_rdata",  ld_rdata, 64'h0000000080000000);
    @(negedge clk);
    check("to_bus_err_end", 64'(bus_err), 64'h0);

    // Ack in WAIT cycle 255 counts as success
    drive(1'b1, 1'b1, 1'b0, 3'b011, 64'h208, 64'h0, 5'd4);
    wc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      valid = 1'b0;
      mem_ack = 1'b0;
      if (!mem_req) break;
      wc++;
      if (wc == 255) begin
        mem_ack = 1'b1; mem_rdata = 64'h0123456789ABCDEF;
      end
    end
    mem_ack = 1'b0;
    check("ack255_wait_cycles", 64'(wc), 64'd255);
    check("ack255_ld_done",     64'(ld_done), 64'h1);
    check("ack255_no_bus_err",  64'(bus_err), 64'h0);
    check("ack255_rdata",       ld_rdata, 64'h0123456789ABCDEF);

    // Reset mid-WAIT, then a stray ack
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 3'b011, 64'h308, 64'h55AA, 5'd2);
    @(negedge clk);
    check("rw_req_before_rst", 64'(mem_req), 64'h1);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 64'hFFFFFFFFFFFFFFFF;
    #1;
    check("rw_req_after_rst",   64'(mem_req), 64'h0);
    check("rw_stall_after_rst", 64'(stall), 64'h0);
    @(negedge clk);
    mem_ack = 1'b0;
    check("rw_ld_done",  64'(ld_done), 64'h0);
    check("rw_bus_err",  64'(bus_err), 64'h0);
    check("rw_req",      64'(mem_req), 64'h0);
    check("rw_we",       64'(mem_we), 64'h0);
    check("rw_addr",     mem_addr, 64'h0);
    check("rw_wdata",    mem_wdata, 64'h0);
    check("rw_wmask",    64'(mem_wmask), 64'h0);
    check("rw_ld_rdata", ld_rdata, 64'h0);
    check("rw_ld_f3",    64'(ld_funct3), 64'h0);
    check("rw_ld_rd",    64'(ld_rd), 64'h0);
    check("rw_stall",    64'(stall), 64'h0);
    check("rw_misalign", 64'(misalign), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 Parameters SHALL be:
  - TIMEOUT, default 255, number of cycles to wait for mem_ack before a bus error.
  - AW, default 64, address width.
REQ-002 Ports SHALL be:
  - clk  in  1  single clock; all state changes on its rising edge.
  - rst  in  1  synchronous, active-high reset.
  - valid  in  1  MEM-stage instruction is valid.
  - is_load  in  1  instruction is a LOAD.
  - is_store  in  1  instruction is a STORE.
  - funct3  in  3  load/store size code: 011 D, 010 W, 110 WU, 001 H, 101 HU.
  - addr  in  AW  effective address (ALU result).
  - wdata  in  64  store data, right-justified.
  - rd  in  5  load destination register.
  - mem_req  out  1  memory request.
  - mem_we  out  1  1 = write.
  - mem_addr  out  AW  doubleword-aligned address, addr with [2:0] forced to 0.
  - mem_wdata  out  64  store data shifted to its byte lane.
  - mem_wmask  out  8  byte enables.
  - mem_ack  in  1  memory completion, one-cycle pulse.
  - mem_rdata  in  64  doubleword read data, valid when mem_ack is 1.
  - stall  out  1  freeze the pipeline.
  - ld_done  out  1  one-cycle pulse: load data valid for writeback.
  - ld_rdata  out  64  read data shifted right by the byte offset.
  - ld_funct3  out  3  captured funct3, forwarded to writeback extension.
  - ld_rd  out  5  captured rd.
  - misalign  out  1  one-cycle pulse on a misaligned access.
  - bus_err  out  1  one-cycle pulse on a memory timeout.

Function
REQ-003 start SHALL be valid & (is_load | is_store) while in IDLE; is_load and is_store both 1 SHALL be treated as a load.
REQ-004 Alignment SHALL be: D requires addr[2:0]==0; W/WU requires addr[1:0]==0; H/HU requires addr[0]==0.
REQ-005 Unlisted funct3 codes SHALL be treated as D.
REQ-006 A misaligned start SHALL pulse misalign in the same cycle (combinational), assert no stall, issue no memory request, and leave the FSM in IDLE.
REQ-007 FSM states SHALL be IDLE, WAIT and DONE.
REQ-008 An aligned start SHALL move IDLE->WAIT and capture addr, wdata, funct3, rd and the load/store flag.
REQ-009 In WAIT, mem_req SHALL be held at 1 and all mem_* outputs held stable until mem_ack.
REQ-010 WAIT->DONE SHALL occur on mem_ack, or when the wait counter reaches TIMEOUT.
REQ-011 DONE->IDLE SHALL occur unconditionally; a start is not accepted while in DONE.
REQ-012 stall SHALL be (IDLE & aligned start) | WAIT, and SHALL be low in DONE so the pipeline advances exactly once per access.
REQ-013 Minimum access latency SHALL be 3 cycles (start cycle, one WAIT cycle with ack, DONE).
REQ-014 Byte offset off SHALL be addr[2:0].
REQ-015 Store byte lanes SHALL be:
  - mem_wmask: D 0xFF, W 0x0F<<off, H 0x03<<off.
  - mem_wdata: wdata<<(8*off).
REQ-016 For a load, mem_wmask SHALL be 0x00.
REQ-017 On a load mem_ack, mem_rdata>>(8*off) SHALL be registered into ld_rdata.
REQ-018 ld_done SHALL pulse 1 in DONE for a load, and SHALL not pulse for a store or after a timeout.
REQ-019 ld_rdata, ld_funct3 and ld_rd SHALL hold their values until the next load completes.
REQ-020 The wait counter SHALL be 8 bits, cleared on entering WAIT and incremented each WAIT cycle without ack.
REQ-021 On timeout, bus_err SHALL pulse in DONE and ld_rdata SHALL retain its previous value.
REQ-022 A mem_ack in the same cycle the counter reaches TIMEOUT SHALL count as success, with no bus_err.
REQ-023 A mem_ack outside WAIT SHALL be ignored.

Reset
REQ-024 rst SHALL put the FSM in IDLE and clear mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, ld_done, ld_rdata, ld_funct3, ld_rd, misalign, bus_err, stall and the counter to 0.
REQ-025 rst during WAIT SHALL abandon the access with no done or error pulse; a late mem_ack after reset SHALL be ignored.

Structure
REQ-026 The shared package SHALL hold the funct3 size codes (LD/LW/LWU/LH/LHU, SD/SW/SH), the LOAD/STORE opcodes and the FSM state encodings.
REQ-027 Lane generation (wmask, wdata shift, rdata shift) SHALL be one combinational sub-module, lsu_lane_align.

Verification
REQ-028 Load LD: addr=0x100, mem_ack one cycle after mem_req with rdata=0x1122334455667788 -> mem_addr=0x100, stall 2 cycles, ld_done pulse, ld_rdata=0x1122334455667788.
REQ-029 Store SH: addr=0x106, wdata=0xBEEF -> mem_wmask=0xC0, mem_wdata=0xBEEF000000000000, mem_we=1, no ld_done.
REQ-030 Load LW: addr=0x104, rdata=0x80000000_00000000 -> ld_rdata[31:0]=0x80000000, ld_funct3=010.
REQ-031 Misaligned LW: addr=0x102 -> misalign pulse the same cycle, mem_req stays 0, stall stays 0.
REQ-032 No ack (TIMEOUT=255) -> bus_err pulse after 255 WAIT cycles, stall released, no ld_done; a second case with ack on cycle 255 -> ld_done, no bus_err.
REQ-033 rst asserted mid-WAIT followed by a stray mem_ack -> all outputs 0, FSM stays IDLE.
